// File: rtl/ctrl_fifo_mem.sv
// ctrl_fifo_mem: FIFO controller for an external single-port memory array.
//
// Each request runs as a short sequence so that the row select is stable
// before, during and after the write strobe. The memory itself lives
// outside this block. Its read data (Do) is combinational from SEL.
//
// Parameters:
//   WS  data word width
//   MS  number of memory rows (width of the one-hot SEL)
//   AW  pointer width, 2**AW must equal MS
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   push, Din   write request and data, sampled only while ready=1
//   pop         read request, sampled only while ready=1
//   Dout        last word read (registered)
//   dout_valid  one-cycle pulse in the first idle cycle after a read
//   ready       high only while idle
//   full        registered, count == MS
//   empty       registered, count == 0
//   SEL         one-hot row select to the memory
//   Wri         write strobe to the memory
//   Di          write data to the memory
//   Do          read data from the memory
//   err         (only with CTRL_FIFO_MEM_ERR_EN) sticky flag, set when a push
//               arrives while full or a pop arrives while empty, in idle
//
// Build option: define CTRL_FIFO_MEM_ERR_EN to add the err output.

module ctrl_fifo_mem #(
   parameter int unsigned WS = 4,
   parameter int unsigned MS = 16,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [WS-1:0] Din,
   input  logic          pop,
   output logic [WS-1:0] Dout,
   output logic          dout_valid,
   output logic          ready,
   output logic          full,
   output logic          empty,
   output logic [MS-1:0] SEL,
   output logic          Wri,
   output logic [WS-1:0] Di,
   input  logic [WS-1:0] Do
`ifdef CTRL_FIFO_MEM_ERR_EN
   ,
   output logic          err
`endif
);

   typedef enum logic [2:0] {
      StIdle,
      StWrSetup,
      StWrPulse,
      StWrHold,
      StRdSetup,
      StRdCapture
   } state_e;

   localparam logic [AW:0] CountMax = (AW+1)'(MS);
   localparam logic [AW:0] CountOne = (AW+1)'(1);

   state_e        state_q;
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   count_q;
   logic          take_pop;
   logic          take_push;

   // Pop wins when both are requested and there is data to read.
   assign take_pop  = pop && !empty;
   assign take_push = push && !full && !take_pop;

   assign ready = (state_q == StIdle);

   function automatic logic [MS-1:0] onehot(input logic [AW-1:0] ptr);
      logic [MS-1:0] v;
      v      = '0;
      v[ptr] = 1'b1;
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         SEL        <= '0;
         Wri        <= 1'b0;
         Di         <= '0;
         Dout       <= '0;
         dout_valid <= 1'b0;
         empty      <= 1'b1;
         full       <= 1'b0;
`ifdef CTRL_FIFO_MEM_ERR_EN
         err        <= 1'b0;
`endif
      end else begin
         dout_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               // SEL is driven while Wri is still low, so the row is
               // settled before the strobe rises.
               if (take_pop) begin
                  SEL     <= onehot(rptr_q);
                  state_q <= StRdSetup;
               end else if (take_push) begin
                  Di      <= Din;
                  SEL     <= onehot(wptr_q);
                  state_q <= StWrSetup;
               end
`ifdef CTRL_FIFO_MEM_ERR_EN
               if ((push && full) || (pop && empty)) begin
                  err <= 1'b1;
               end
`endif
            end
            StWrSetup: begin
               Wri     <= 1'b1;
               state_q <= StWrPulse;
            end
            StWrPulse: begin
               Wri     <= 1'b0;
               state_q <= StWrHold;
            end
            StWrHold: begin
               SEL     <= '0;
               wptr_q  <= wptr_q + 1'b1;
               count_q <= count_q + CountOne;
               full    <= ((count_q + CountOne) == CountMax);
               empty   <= 1'b0;
               state_q <= StIdle;
            end
            StRdSetup: begin
               state_q <= StRdCapture;
            end
            StRdCapture: begin
               Dout       <= Do;
               SEL        <= '0;
               rptr_q     <= rptr_q + 1'b1;
               count_q    <= count_q - CountOne;
               full       <= 1'b0;
               empty      <= (count_q == CountOne);
               dout_valid <= 1'b1;
               state_q    <= StIdle;
            end
            default: begin
               SEL     <= '0;
               Wri     <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
